// File: rtl/fetch_queue_ctrl.sv
// Fetch-packet queue between IF and the FIFO->ID register: circular buffer of
// {inst0, inst1, pc} with first-word fall-through head and valid/ready handshakes.
`ifndef INST_NOP
`define INST_NOP 32'h0340_0000
`endif
`ifndef PC_RESET
`define PC_RESET 32'h1c00_0000
`endif

module fetch_queue_ctrl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fifo_flush,
    input  logic             fifo_stall,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_inst0,
    input  logic [31:0]      if_inst1,
    input  logic [31:0]      if_pc,
    output logic             fifo_valid,
    input  logic             fifo_ready,
    output logic [31:0]      fifo_inst0,
    output logic [31:0]      fifo_inst1,
    output logic [31:0]      fifo_pc,
    output logic             fetch_buf_empty,
    output logic             fetch_buf_full,
    output logic [PTR_W:0]   fetch_buf_count
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   ZERO_CNT = (PTR_W + 1)'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

    logic [95:0]      storage_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_s;
    logic             pop_s;
    logic [95:0]      head_s;

    // Status, handshake gating and NOP-forced head decode.
    always_comb begin
        fetch_buf_count = count_r;
        fetch_buf_empty = (count_r == ZERO_CNT);
        fetch_buf_full  = (count_r == FULL_CNT);
        if_ready        = !fetch_buf_full;
        fifo_valid      = !fetch_buf_empty;
        push_s          = if_valid & if_ready & !fifo_flush;
        pop_s           = fifo_valid & fifo_ready & !fifo_stall & !fifo_flush;
        head_s          = storage_r[rd_ptr_r];
        if (fetch_buf_empty) begin
            fifo_inst0 = `INST_NOP;
            fifo_inst1 = `INST_NOP;
            fifo_pc    = `PC_RESET;
        end else begin
            fifo_inst0 = head_s[95:64];
            fifo_inst1 = head_s[63:32];
            fifo_pc    = head_s[31:0];
        end
    end

    // Packet storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            storage_r[wr_ptr_r] <= {if_inst0, if_inst1, if_pc};
        end
    end

    // Pointer and occupancy update; flush wins over any same-cycle push/pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= ZERO_CNT;
        end else if (fifo_flush) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= ZERO_CNT;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Scoreboard bench for fetch_queue_ctrl: a queue-based model tracks accepted
// packets; a negedge monitor compares status and head outputs every cycle.
module tb_fetch_queue_ctrl;

    localparam int          DEPTH   = 8;
    localparam logic [31:0] NOP_C   = 32'h0340_0000;
    localparam logic [31:0] PCRST_C = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fifo_flush = 1'b0;
    logic        fifo_stall = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_inst0 = 32'h0;
    logic [31:0] if_inst1 = 32'h0;
    logic [31:0] if_pc = 32'h0;
    logic        fifo_valid;
    logic        fifo_ready = 1'b0;
    logic [31:0] fifo_inst0;
    logic [31:0] fifo_inst1;
    logic [31:0] fifo_pc;
    logic        fetch_buf_empty;
    logic        fetch_buf_full;
    logic [3:0]  fetch_buf_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [95:0] q[$];
    logic [31:0] got_pc[$];

    fetch_queue_ctrl #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rstn(rstn), .fifo_flush(fifo_flush), .fifo_stall(fifo_stall),
        .if_valid(if_valid), .if_ready(if_ready), .if_inst0(if_inst0),
        .if_inst1(if_inst1), .if_pc(if_pc), .fifo_valid(fifo_valid),
        .fifo_ready(fifo_ready), .fifo_inst0(fifo_inst0), .fifo_inst1(fifo_inst1),
        .fifo_pc(fifo_pc), .fetch_buf_empty(fetch_buf_empty),
        .fetch_buf_full(fetch_buf_full), .fetch_buf_count(fetch_buf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare DUT against the model, then apply the coming edge to the model.
    always @(negedge clk) begin
        int n;
        bit do_pop;
        bit do_push;
        n = q.size();
        check("if_ready", 96'(if_ready), 96'(n < DEPTH));
        check("fifo_valid", 96'(fifo_valid), 96'(n > 0));
        check("empty", 96'(fetch_buf_empty), 96'(n == 0));
        check("full", 96'(fetch_buf_full), 96'(n == DEPTH));
        check("count", 96'(fetch_buf_count), 96'(n));
        if (n > 0)
            check("head", {fifo_inst0, fifo_inst1, fifo_pc}, q[0]);
        else
            check("nop_head", {fifo_inst0, fifo_inst1, fifo_pc}, {NOP_C, NOP_C, PCRST_C});
        if (!rstn) begin
            q.delete();
        end else if (fifo_flush) begin
            q.delete();
        end else begin
            do_pop  = (n > 0) && fifo_ready && !fifo_stall;
            do_push = if_valid && (n < DEPTH);
            if (do_pop) begin
                got_pc.push_back(fifo_pc);
                void'(q.pop_front());
            end
            if (do_push) q.push_back({if_inst0, if_inst1, if_pc});
        end
    end

    task automatic drive(input bit v, input bit rdy, input bit stl, input bit fl,
                         input logic [31:0] pc);
        @(posedge clk);
        #1;
        if_valid   = v;
        fifo_ready = rdy;
        fifo_stall = stl;
        fifo_flush = fl;
        if_pc      = pc;
        if_inst0   = $urandom;
        if_inst1   = $urandom;
    endtask

    initial begin
        logic [31:0] base;
        base = 32'h1c00_0000;
        // Reset
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Single packet with the documented encoding
        @(posedge clk);
        #1;
        if_valid = 1'b1; fifo_ready = 1'b0;
        if_inst0 = 32'h0280_0421; if_inst1 = 32'h0280_0842; if_pc = base;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Fill to full, hold a 9th packet, then a single pop admits it
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, base + 32'(i * 4));
        repeat (3) @(posedge clk);
        #1 fifo_ready = 1'b1;
        @(posedge clk);
        #1 fifo_ready = 1'b0;
        @(posedge clk);
        #1 if_valid = 1'b0; fifo_ready = 1'b1;
        repeat (10) @(posedge clk);

        // Wrap: 12 in-order packets with fifo_ready toggling
        #1 got_pc.delete();
        for (int i = 0; i < 12; i++) drive(1'b1, 1'(i % 2), 1'b0, 1'b0, base + 32'(i * 4));
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_n", 96'(got_pc.size()), 96'(12));
        for (int i = 0; i < 12 && i < got_pc.size(); i++)
            check("wrap_pc", 96'(got_pc[i]), 96'(base + 32'(i * 4)));

        // Flush with a same-cycle push at count 5
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h2000_0000 + 32'(i * 4));
        drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h2fff_fff0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Stall at count 3 while pushing, then release
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000_0000 + 32'(i * 4));
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h3000_0100 + 32'(i * 4));
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 99) < 10), 1'($urandom_range(0, 99) < 3), $urandom);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h4000_0000 + 32'(i * 4));
        @(posedge clk);
        #2 rstn = 1'b0;
        q.delete();
        #1;
        check("arst_count", 96'(fetch_buf_count), 96'(0));
        check("arst_valid", 96'(fifo_valid), 96'(0));
        check("arst_pc", 96'(fifo_pc), 96'(PCRST_C));
        @(posedge clk);
        #1 rstn = 1'b1; if_valid = 1'b0;
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
